// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// hands the returned word to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    input  logic [WIDTH-1:0] branch_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             valid_q, valid_d;
    logic             req_q;
    logic [WIDTH-1:0] target_sum;
    logic [WIDTH-1:0] target;

    assign target_sum = branch_pc + ImmOp;
    assign target     = {target_sum[WIDTH-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (valid_q && instr_ready) begin
                    pc_d    = pc_q + WIDTH'(4);
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; any in-flight response becomes stale.
        if (PCsrc) begin
            pc_d       = target;
            valid_d    = 1'b0;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            case (state_q)
                S_FETCH:         state_d = S_DRAIN;
                S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                default:         state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            req_q      <= (state_d == S_FETCH);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic [31:0] branch_pc;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cnt   = 0;
    logic [31:0] lat_addr = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .branch_pc   (branch_pc)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h0050_0193;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Memory: answers each request `lat` cycles later with word(addr).
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(lat_addr);
                end
            end
            if (imem_req) begin
                cnt      = lat;
                lat_addr = imem_addr;
            end
        end
    end

    // Reference model: tracks outstanding/stale requests and the presented word.
    logic        m_req, m_pend, m_stale, m_valid;
    logic [31:0] m_pc, m_instr, m_ipc;

    always @(posedge clk or negedge rst_n) begin
        logic        n_pend, n_valid, capture, accept;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_req = 1'b0; m_pend = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
            m_pc = 32'h100; m_instr = '0; m_ipc = '0;
        end else begin
            tgt     = (branch_pc + ImmOp) & ~32'h3;
            accept  = m_valid && instr_ready;
            capture = imem_rvalid && m_pend && !m_stale && !PCsrc;
            n_pend  = (m_pend && !imem_rvalid) || m_req;
            m_stale = n_pend && (m_stale || PCsrc);
            n_valid = m_valid;
            if (PCsrc) n_valid = 1'b0;
            else if (capture) begin
                n_valid = 1'b1;
                m_instr = imem_rdata;
                m_ipc   = m_pc;
            end else if (accept) n_valid = 1'b0;
            m_pc    = PCsrc ? tgt : (accept ? m_pc + 32'd4 : m_pc);
            m_pend  = n_pend;
            m_valid = n_valid;
            m_req   = !n_pend && !n_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_req",   {31'b0, imem_req},    {31'b0, m_req});
            chk("m_addr",  imem_addr,            m_pc);
            chk("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            chk("m_instr", instr,                m_instr);
            chk("m_ipc",   instr_pc,             m_ipc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input string nm);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            total++; bad++;
            $display("FAIL %s: timeout, imem_req never rose (want addr %h)", nm, addr);
        end else chk(nm, imem_addr, addr);
    endtask

    task automatic wait_valid(input logic [31:0] pc, input string nm);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            total++; bad++;
            $display("FAIL %s: timeout, instr_valid never rose (want pc %h)", nm, pc);
        end else begin
            chk({nm, "_pc"}, instr_pc, pc);
            chk({nm, "_instr"}, instr, word(pc));
        end
    endtask

    task automatic redirect(input logic [31:0] bpc, input logic [31:0] imm, input logic rdy);
        PCsrc = 1'b1; branch_pc = bpc; ImmOp = imm; instr_ready = rdy;
        step();
        PCsrc = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; branch_pc = '0; ImmOp = '0;
        repeat (3) step();
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'h100);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_ipc",   instr_pc,             32'd0);
        rst_n = 1'b1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("first_req",  {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h100);
        step();
        chk("wait_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_instr", instr,                32'h0050_0093);
        chk("first_ipc",   instr_pc,             32'h100);

        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'b0, instr_valid}, 32'd1);
            chk("bp_instr", instr,                32'h0050_0093);
            chk("bp_req",   {31'b0, imem_req},    32'd0);
        end
        accept();
        wait_req(32'h104, "next_addr");
        wait_valid(32'h104, "v104");

        redirect(32'h100, 32'h100, 1'b0);
        wait_req(32'h200, "addr200");
        step();
        redirect(32'h1F0, 32'hFFFF_FFF0, 1'b0);
        chk("wait_redir_valid", {31'b0, instr_valid}, 32'd0);
        wait_req(32'h1E0, "redir_wait_addr");
        wait_valid(32'h1E0, "v1e0");

        lat = 3;
        accept();
        wait_req(32'h1E4, "addr1e4");
        step();
        redirect(32'h40, 32'h0, 1'b0);
        wait_req(32'h40, "drain_addr");
        chk("drain_valid", {31'b0, instr_valid}, 32'd0);
        wait_valid(32'h40, "v40");
        lat = 1;

        redirect(32'h300, 32'h20, 1'b1);
        wait_req(32'h320, "hs_redir_addr");
        redirect(32'h500, 32'h8, 1'b0);
        wait_req(32'h508, "fetch_redir_addr");
        wait_valid(32'h508, "v508");

        redirect(32'hFFFF_FFF0, 32'hC, 1'b0);
        wait_req(32'hFFFF_FFFC, "addr_top");
        wait_valid(32'hFFFF_FFFC, "vtop");
        accept();
        wait_req(32'h0, "wrap_addr");
        wait_valid(32'h0, "v0");
        redirect(32'h10, 32'h3, 1'b0);
        wait_req(32'h10, "align_addr");
        wait_valid(32'h10, "v10");

        lat = 3;
        accept();
        wait_req(32'h14, "addr14");
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_req",   {31'b0, imem_req},    32'd0);
        chk("midrst_addr",  imem_addr,            32'h100);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        wait_req(32'h100, "restart_addr");
        wait_valid(32'h100, "vrestart");
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
